// File: rtl/ifft_4point_16bit.sv
// rtl/ifft_4point_16bit.sv - 4-point radix-2 inverse FFT with one shared butterfly, start/done handshake
// Define IFFT_ROUND_EN to round the 1/N scaling half toward +inf instead of truncating.
module ifft_4point_16bit #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*DATA_W-1:0] bin0_in,
  input  logic [2*DATA_W-1:0] bin1_in,
  input  logic [2*DATA_W-1:0] bin2_in,
  input  logic [2*DATA_W-1:0] bin3_in,
  output logic [2*DATA_W-1:0] time0_out,
  output logic [2*DATA_W-1:0] time1_out,
  output logic [2*DATA_W-1:0] time2_out,
  output logic [2*DATA_W-1:0] time3_out,
  output logic                busy,
  output logic                done
);

  localparam int IW = DATA_W + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_S1A, S_S1B, S_S2A, S_S2B, S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2*DATA_W-1:0] r_x0, r_x1, r_x2, r_x3;
  logic signed [IW-1:0] r_a0_re, r_a0_im, r_a1_re, r_a1_im;
  logic signed [IW-1:0] r_a2_re, r_a2_im, r_t_re, r_t_im;

  logic signed [IW-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
  logic signed [IW-1:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;

  function automatic logic signed [IW-1:0] re_ext(input logic [2*DATA_W-1:0] w);
    return IW'($signed(w[2*DATA_W-1:DATA_W]));
  endfunction

  function automatic logic signed [IW-1:0] im_ext(input logic [2*DATA_W-1:0] w);
    return IW'($signed(w[DATA_W-1:0]));
  endfunction

  // 1/N factor of the inverse transform
  function automatic logic [DATA_W-1:0] scale(input logic signed [IW-1:0] v);
`ifdef IFFT_ROUND_EN
    logic signed [IW:0] r;
    r = {v[IW-1], v} + (IW+1)'(2);
    return r[DATA_W+1:2];
`else
    return v[DATA_W+1:2];
`endif
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_S1A;
      S_S1A:   w_next = S_S1B;
      S_S1B:   w_next = S_S2A;
      S_S2A:   w_next = S_S2B;
      S_S2B:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Butterfly operand selection; each compute state feeds the one adder/subtractor pair
  always_comb begin
    w_a_re = '0;
    w_a_im = '0;
    w_b_re = '0;
    w_b_im = '0;
    case (r_state)
      S_S1A: begin
        w_a_re = re_ext(r_x0); w_a_im = im_ext(r_x0);
        w_b_re = re_ext(r_x2); w_b_im = im_ext(r_x2);
      end
      S_S1B: begin
        w_a_re = re_ext(r_x1); w_a_im = im_ext(r_x1);
        w_b_re = re_ext(r_x3); w_b_im = im_ext(r_x3);
      end
      S_S2A: begin
        w_a_re = r_a0_re; w_a_im = r_a0_im;
        w_b_re = r_a2_re; w_b_im = r_a2_im;
      end
      S_S2B: begin
        w_a_re = r_a1_re; w_a_im = r_a1_im;
        w_b_re = r_t_re;  w_b_im = r_t_im;
      end
      default: ;
    endcase
  end

  assign w_sum_re = w_a_re + w_b_re;
  assign w_sum_im = w_a_im + w_b_im;
  assign w_dif_re = w_a_re - w_b_re;
  assign w_dif_im = w_a_im - w_b_im;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_x0      <= '0;
      r_x1      <= '0;
      r_x2      <= '0;
      r_x3      <= '0;
      r_a0_re   <= '0;
      r_a0_im   <= '0;
      r_a1_re   <= '0;
      r_a1_im   <= '0;
      r_a2_re   <= '0;
      r_a2_im   <= '0;
      r_t_re    <= '0;
      r_t_im    <= '0;
      time0_out <= '0;
      time1_out <= '0;
      time2_out <= '0;
      time3_out <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x0 <= bin0_in;
            r_x1 <= bin1_in;
            r_x2 <= bin2_in;
            r_x3 <= bin3_in;
          end
        end
        S_S1A: begin
          r_a0_re <= w_sum_re;
          r_a0_im <= w_sum_im;
          r_a1_re <= w_dif_re;
          r_a1_im <= w_dif_im;
        end
        S_S1B: begin
          r_a2_re <= w_sum_re;
          r_a2_im <= w_sum_im;
          // j*(X1-X3)
          r_t_re  <= -w_dif_im;
          r_t_im  <= w_dif_re;
        end
        S_S2A: begin
          time0_out <= {scale(w_sum_re), scale(w_sum_im)};
          time2_out <= {scale(w_dif_re), scale(w_dif_im)};
        end
        S_S2B: begin
          time1_out <= {scale(w_sum_re), scale(w_sum_im)};
          time3_out <= {scale(w_dif_re), scale(w_dif_im)};
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);

endmodule
